// File: rtl/ysyx_22050039_fetch_unit.sv
// ysyx_22050039_fetch_unit: RV64 fetch stage owning the PC, one outstanding
// memory request at a time, holding each instruction for decode until consumed.
module ysyx_22050039_fetch_unit #(
  parameter int XLEN = 64,
  parameter int INST_LEN = 32,
  parameter logic [XLEN-1:0] RESET_PC = 64'h8000_0000
) (
  input  logic                clk,
  input  logic                rst,
  output logic                req_valid,
  output logic [XLEN-1:0]     req_addr,
  input  logic                req_ready,
  input  logic                resp_valid,
  input  logic [INST_LEN-1:0] resp_data,
  output logic [INST_LEN-1:0] inst,
  output logic [XLEN-1:0]     inst_pc,
  output logic                inst_valid,
  input  logic                inst_ready,
  input  logic                pc_wen,
  input  logic [XLEN-1:0]     dnpc,
  output logic                fetch_err,
  output logic [XLEN-1:0]     inst_cnt
);
  typedef enum logic [2:0] {IDLE, REQ, WAIT, HOLD, FAULT} state_t;
  state_t state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d, inst_pc_q, inst_pc_d, cnt_q, cnt_d;
  logic [INST_LEN-1:0] inst_q, inst_d;
  logic err_q, err_d, kill_q, kill_d, redir;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      pc_q      <= RESET_PC;
      inst_q    <= '0;
      inst_pc_q <= RESET_PC;
      cnt_q     <= '0;
      err_q     <= 1'b0;
      kill_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      inst_q    <= inst_d;
      inst_pc_q <= inst_pc_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
      kill_q    <= kill_d;
    end
  end
  assign redir = pc_wen && (state_q == REQ || state_q == WAIT || state_q == HOLD);
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    inst_d    = inst_q;
    inst_pc_d = inst_pc_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    kill_d    = kill_q;
    case (state_q)
      IDLE: state_d = REQ;
      REQ: begin
        if (req_ready) begin
          state_d = WAIT;
          kill_d  = pc_wen;
        end
      end
      WAIT: begin
        if (resp_valid) begin
          kill_d  = 1'b0;
          state_d = (kill_q || pc_wen) ? REQ : HOLD;
          if (!kill_q && !pc_wen) begin
            inst_d    = resp_data;
            inst_pc_d = pc_q;
          end
        end else if (pc_wen) kill_d = 1'b1;
      end
      HOLD: begin
        if (inst_ready) begin
          cnt_d = cnt_q + XLEN'(1);
          pc_d  = pc_q + XLEN'(4);
        end
        if (inst_ready || pc_wen) state_d = REQ;
      end
      default: ;
    endcase
    // a misaligned target faults instead of redirecting, leaving pc untouched
    if (redir) begin
      pc_d = (dnpc[1:0] != 2'b00) ? pc_q : dnpc;
      if (dnpc[1:0] != 2'b00) begin
        err_d   = 1'b1;
        state_d = FAULT;
      end
    end
  end
  assign req_valid  = state_q == REQ;
  assign req_addr   = pc_q;
  assign inst_valid = state_q == HOLD;
  assign inst       = inst_q;
  assign inst_pc    = inst_pc_q;
  assign fetch_err  = err_q;
  assign inst_cnt   = cnt_q;
endmodule

// File: tb/tb_ysyx_22050039_fetch_unit.sv
// tb_ysyx_22050039_fetch_unit: scenario tasks with a scoreboard of expected
// (inst, inst_pc) pairs pushed when a response is driven, popped on inst_valid.
module tb_ysyx_22050039_fetch_unit;
  logic clk = 1'b0, rst = 1'b1;
  logic req_valid, req_ready = 1'b0, resp_valid = 1'b0, inst_valid, inst_ready = 1'b0;
  logic pc_wen = 1'b0, fetch_err;
  logic [63:0] req_addr, inst_pc, dnpc = '0, inst_cnt;
  logic [31:0] resp_data = '0, inst;
  typedef struct packed {logic [31:0] i; logic [63:0] pc;} exp_t;
  exp_t q[$];
  exp_t e;
  int checks = 0, failures = 0;

  ysyx_22050039_fetch_unit dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
    .resp_valid(resp_valid), .resp_data(resp_data), .inst(inst), .inst_pc(inst_pc),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .pc_wen(pc_wen), .dnpc(dnpc),
    .fetch_err(fetch_err), .inst_cnt(inst_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] d, input logic push, input logic [63:0] pc);
    if (push) q.push_back({d, pc});
    req_ready = 1'b1;
    tick();
    req_ready = 1'b0;
    resp_valid = 1'b1;
    resp_data = d;
    tick();
    resp_valid = 1'b0;
  endtask

  task automatic pop_exp;
    e = q.size() != 0 ? q.pop_front() : '0;
  endtask

  task automatic test_reset;
    tick(); tick();
    checks++;
    if (req_valid !== 1'b0 || inst_valid !== 1'b0 || req_addr !== 64'h80000000 || inst !== 32'h0 ||
        inst_pc !== 64'h80000000 || inst_cnt !== 64'h0 || fetch_err !== 1'b0) begin
      failures++;
      $display("FAIL reset: rv=%b iv=%b addr=%h inst=%h ipc=%h cnt=%0d err=%b required 0 0 80000000 0 80000000 0 0",
               req_valid, inst_valid, req_addr, inst, inst_pc, inst_cnt, fetch_err);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (req_valid !== 1'b1 || req_addr !== 64'h80000000) begin
      failures++;
      $display("FAIL first_req: rv=%b addr=%h required 1 80000000", req_valid, req_addr);
    end
  endtask

  task automatic test_basic_fetch;
    req_ready = 1'b1;
    q.push_back({32'h00100093, 64'h80000000});
    tick();
    req_ready = 1'b0;
    checks++;
    if (req_valid !== 1'b0 || inst_valid !== 1'b0) begin
      failures++;
      $display("FAIL wait_quiet: rv=%b iv=%b required 0 0", req_valid, inst_valid);
    end
    resp_valid = 1'b1;
    resp_data = 32'h00100093;
    tick();
    resp_valid = 1'b0;
    pop_exp();
    checks++;
    if (inst_valid !== 1'b1 || inst !== e.i || inst_pc !== e.pc) begin
      failures++;
      $display("FAIL basic_inst: iv=%b inst=%h pc=%h required 1 %h %h", inst_valid, inst, inst_pc, e.i, e.pc);
    end
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;
    checks++;
    if (req_valid !== 1'b1 || req_addr !== 64'h80000004 || inst_cnt !== 64'd1) begin
      failures++;
      $display("FAIL basic_next: rv=%b addr=%h cnt=%0d required 1 80000004 1", req_valid, req_addr, inst_cnt);
    end
  endtask

  task automatic test_stall_redirect;
    issue(32'h00208113, 1'b1, 64'h80000004);
    pop_exp();
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (inst_valid !== 1'b1 || inst !== e.i || inst_pc !== e.pc || req_valid !== 1'b0 || inst_cnt !== 64'd1) begin
        failures++;
        $display("FAIL stall[%0d]: iv=%b inst=%h pc=%h rv=%b cnt=%0d required 1 %h %h 0 1",
                 k, inst_valid, inst, inst_pc, req_valid, inst_cnt, e.i, e.pc);
      end
      tick();
    end
    inst_ready = 1'b1;
    pc_wen = 1'b1;
    dnpc = 64'h80000100;
    tick();
    inst_ready = 1'b0;
    pc_wen = 1'b0;
    checks++;
    if (req_valid !== 1'b1 || req_addr !== 64'h80000100 || inst_cnt !== 64'd2) begin
      failures++;
      $display("FAIL hold_redirect: rv=%b addr=%h cnt=%0d required 1 80000100 2", req_valid, req_addr, inst_cnt);
    end
  endtask

  task automatic test_kill_wait;
    logic seen = 1'b0;
    req_ready = 1'b1;
    tick();
    req_ready = 1'b0;
    pc_wen = 1'b1;
    dnpc = 64'h80000200;
    tick();
    pc_wen = 1'b0;
    resp_valid = 1'b1;
    resp_data = 32'hdeadbeef;
    tick();
    resp_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      seen |= inst_valid;
      tick();
    end
    checks++;
    if (seen !== 1'b0 || req_valid !== 1'b1 || req_addr !== 64'h80000200 || inst_cnt !== 64'd2) begin
      failures++;
      $display("FAIL kill_wait: iv_seen=%b rv=%b addr=%h cnt=%0d required 0 1 80000200 2", seen, req_valid, req_addr, inst_cnt);
    end
    issue(32'h12345678, 1'b1, 64'h80000200);
    pop_exp();
    checks++;
    if (inst_valid !== 1'b1 || inst !== e.i || inst_pc !== e.pc) begin
      failures++;
      $display("FAIL after_kill: iv=%b inst=%h pc=%h required 1 %h %h", inst_valid, inst, inst_pc, e.i, e.pc);
    end
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;
  endtask

  task automatic test_back_to_back;
    checks++;
    if (req_addr !== 64'h80000204 || inst_cnt !== 64'd3) begin
      failures++;
      $display("FAIL seq_addr: addr=%h cnt=%0d required 80000204 3", req_addr, inst_cnt);
    end
    req_ready = 1'b1;
    resp_valid = 1'b1;
    resp_data = 32'h00000bad;
    q.push_back({32'h00c00513, 64'h80000204});
    tick();
    req_ready = 1'b0;
    checks++;
    if (inst_valid !== 1'b0) begin
      failures++;
      $display("FAIL same_cycle_resp: iv=%b required 0", inst_valid);
    end
    resp_data = 32'h00c00513;
    tick();
    resp_valid = 1'b0;
    pop_exp();
    checks++;
    if (inst_valid !== 1'b1 || inst !== e.i || inst_pc !== e.pc) begin
      failures++;
      $display("FAIL late_resp: iv=%b inst=%h pc=%h required 1 %h %h", inst_valid, inst, inst_pc, e.i, e.pc);
    end
  endtask

  task automatic test_misaligned;
    logic bad = 1'b0;
    inst_ready = 1'b1;
    pc_wen = 1'b1;
    dnpc = 64'h80000102;
    tick();
    inst_ready = 1'b0;
    pc_wen = 1'b0;
    checks++;
    if (fetch_err !== 1'b1 || inst_cnt !== 64'd4 || req_addr !== 64'h80000204) begin
      failures++;
      $display("FAIL misalign: err=%b cnt=%0d addr=%h required 1 4 80000204", fetch_err, inst_cnt, req_addr);
    end
    req_ready = 1'b1;
    resp_valid = 1'b1;
    inst_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      bad |= req_valid | inst_valid | ~fetch_err | (req_addr != 64'h80000204);
      tick();
    end
    req_ready = 1'b0;
    resp_valid = 1'b0;
    inst_ready = 1'b0;
    checks++;
    if (bad !== 1'b0) begin
      failures++;
      $display("FAIL fault_stuck: activity=%b required 0", bad);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (fetch_err !== 1'b0) begin
      failures++;
      $display("FAIL err_clear: err=%b required 0", fetch_err);
    end
    tick();
    rst = 1'b0;
    tick();
    checks++;
    if (req_valid !== 1'b1 || req_addr !== 64'h80000000) begin
      failures++;
      $display("FAIL refetch: rv=%b addr=%h required 1 80000000", req_valid, req_addr);
    end
  endtask

  task automatic test_async_reset;
    issue(32'h00500293, 1'b1, 64'h80000000);
    pop_exp();
    checks++;
    if (inst_valid !== 1'b1 || inst !== e.i || inst_pc !== e.pc) begin
      failures++;
      $display("FAIL pre_reset: iv=%b inst=%h pc=%h required 1 %h %h", inst_valid, inst, inst_pc, e.i, e.pc);
    end
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;
    req_ready = 1'b1;
    tick();
    req_ready = 1'b0;
    #2 rst = 1'b1;
    #1;
    checks++;
    if (req_valid !== 1'b0 || inst_valid !== 1'b0 || req_addr !== 64'h80000000 || inst !== 32'h0 ||
        inst_pc !== 64'h80000000 || inst_cnt !== 64'h0 || fetch_err !== 1'b0) begin
      failures++;
      $display("FAIL async_reset: rv=%b iv=%b addr=%h inst=%h ipc=%h cnt=%0d err=%b required 0 0 80000000 0 80000000 0 0",
               req_valid, inst_valid, req_addr, inst, inst_pc, inst_cnt, fetch_err);
    end
    tick();
    rst = 1'b0;
    tick();
    checks++;
    if (req_valid !== 1'b1 || req_addr !== 64'h80000000 || q.size() != 0) begin
      failures++;
      $display("FAIL post_reset: rv=%b addr=%h pending=%0d required 1 80000000 0", req_valid, req_addr, q.size());
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_basic_fetch();
    test_stall_redirect();
    test_kill_wait();
    test_back_to_back();
    test_misaligned();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ysyx_22050039_fetch_unit.md
# ysyx_22050039_fetch_unit

Instruction fetch stage of the ysyx_22050039 RV64 core, directly upstream of the instruction decoder. It owns the architectural PC. It issues one 32-bit fetch at a time over a valid/ready memory request channel and holds the returned instruction for decode under a valid/ready handshake. It applies PC redirects (jal/jalr) from the execute side and counts instructions retired.

## Interface
- XLEN, 64, PC and data width
- INST_LEN, 32, instruction width
- RESET_PC, 64'h8000_0000, PC value loaded at reset
- clk  input  1  core clock; all state changes on rising edge
- rst  input  1  asynchronous, active-high reset
- req_valid  output  1  fetch request valid (state REQ)
- req_addr  output  XLEN  fetch address, equals pc
- req_ready  input  1  memory accepts request this cycle
- resp_valid  input  1  memory returns instruction this cycle
- resp_data  input  INST_LEN  returned instruction word
- inst  output  INST_LEN  instruction presented to decode
- inst_pc  output  XLEN  PC of inst
- inst_valid  output  1  inst is valid (state HOLD)
- inst_ready  input  1  decode/execute consumes inst this cycle
- pc_wen  input  1  redirect request; next PC is dnpc
- dnpc  input  XLEN  redirect target
- fetch_err  output  1  sticky misaligned-target fault
- inst_cnt  output  XLEN  number of instructions consumed since reset

## Operation
- States: IDLE, REQ, WAIT, HOLD, FAULT. Reset state is IDLE.
- Reset values: pc=RESET_PC, inst=0, inst_pc=RESET_PC, inst_cnt=0, fetch_err=0, kill=0. req_valid=0 and inst_valid=0.
- IDLE: unconditionally to REQ on the next edge.
- REQ: req_valid=1, req_addr=pc. On req_ready go to WAIT. resp_valid in REQ is ignored.
- WAIT: on resp_valid with kill=0, latch inst<=resp_data and inst_pc<=pc, then go to HOLD. On resp_valid with kill=1, discard the data, clear kill, and go to REQ.
- HOLD: inst_valid=1. inst and inst_pc are stable until the handshake. On inst_ready: pc<=pc_wen ? dnpc : pc+4, inst_cnt<=inst_cnt+1, go to REQ.
- Redirect outside a HOLD handshake (pc_wen=1):
  - In REQ without req_ready: pc<=dnpc, stay in REQ. The address may change while req_ready is low.
  - In REQ with req_ready: pc<=dnpc, kill<=1, go to WAIT.
  - In WAIT without resp_valid: pc<=dnpc, kill<=1.
  - In WAIT with resp_valid: pc<=dnpc, discard the data, go to REQ.
  - In HOLD without inst_ready: pc<=dnpc, drop the held instruction, go to REQ.
  - In IDLE or FAULT: ignored.
- Misalignment: any accepted redirect with dnpc[1:0]!=0 sets fetch_err=1 and goes to FAULT. pc is not updated. In the HOLD handshake case inst_cnt still increments.
- FAULT: req_valid=0 and inst_valid=0. Exits only on rst.
- pc+4 and inst_cnt+1 wrap modulo 2^XLEN.
- Only one request is outstanding at a time. No new request is issued while in WAIT.

## Timing
- Cycle 0 is the first edge after rst deasserts: IDLE to REQ.
- Best-case fetch: req_ready in the first REQ cycle, resp_valid in the next cycle. inst_valid rises 2 cycles after REQ entry. Throughput is at most one instruction per 3 cycles.
- Response latency is at least 1 cycle after acceptance. A resp_valid in the same cycle as acceptance is ignored.
- Asserting rst mid-operation forces all outputs to their reset values immediately, regardless of clk. A pending response is lost, and memory must tolerate this.
- pc_wen and dnpc are sampled only on the edge. dnpc is a don't-care when pc_wen=0.

## Test plan
- Reset, then req_ready=1 always and resp_valid one cycle after acceptance with data 0x00100093 -> req_addr=0x80000000, inst=0x00100093, inst_pc=0x80000000, inst_valid high in the cycle after the response. With inst_ready=1, the next req_addr is 0x80000004 and inst_cnt=1.
- Hold inst_ready=0 for 5 cycles in HOLD -> inst and inst_pc are stable, req_valid=0, inst_cnt unchanged.
- HOLD handshake with pc_wen=1, dnpc=0x80000100 -> next req_addr=0x80000100, inst_cnt incremented.
- pc_wen=1, dnpc=0x80000200 while in WAIT, then resp_valid with 0xdeadbeef -> data discarded, inst_valid never asserts for it, next req_addr=0x80000200.
- HOLD handshake with pc_wen=1, dnpc=0x80000102 -> fetch_err=1, req_valid and inst_valid stay 0 for 10 cycles, pc unchanged. A later rst clears fetch_err and refetches from 0x80000000.
- Assert rst asynchronously while in WAIT -> outputs return to reset values before the next clk edge, inst_cnt=0.
